// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared constants and next-PC source encoding for the
//                PC sequencer and its return-address stack.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_1000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;

    localparam int OFFSET_MSB = 15;
    localparam int JIDX_MSB   = 25;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        JR   = 3'd3,
        RET  = 3'd4,
        TRAP = 3'd5
    } next_src_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Fetch/decode-side bundle of the PC sequencer. The core is
//                the master (drives controls), the sequencer is the slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic [31:0]       instruction;
    logic              zero;
    logic              branch_sel;
    logic              jump_sel;
    logic              link_sel;
    logic              jr_sel;
    logic              ret_sel;
    logic [ADDR_W-1:0] rs_data;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] link_addr;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_miss;
    logic              misalign_fault;

    modport master (
        output stall, instruction, zero, branch_sel, jump_sel, link_sel,
               jr_sel, ret_sel, rs_data,
        input  pc, pc_plus4, link_addr, ras_count, ras_miss, misalign_fault
    );

    modport slave (
        input  stall, instruction, zero, branch_sel, jump_sel, link_sel,
               jr_sel, ret_sel, rs_data,
        output pc, pc_plus4, link_addr, ras_count, ras_miss, misalign_fault
    );

endinterface
`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Circular return-address stack. A push when full overwrites
//                the oldest entry; a pop when empty is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module ras_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic                     hold,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         top,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          empty,
    output logic                          full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_inc;

    assign w_top_inc = r_top + PTR_W'(1);
    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign top       = r_mem[r_top];

    // Pointer wrap on push makes the new top land on the oldest slot when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (!hold) begin
            if (push) begin
                r_top   <= w_top_inc;
                r_count <= full ? r_count : r_count + CNT_W'(1);
            end else if (pop && !empty) begin
                r_top   <= r_top - PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !hold && push) begin
            r_mem[w_top_inc] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Registered next-PC generator with stall, return-address
//                stack prediction and misaligned-target trap.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF,
    parameter int          RAS_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pc_sequencer_if.slave      bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] c_trap_pc  = ADDR_W'(TRAP_VEC);

    logic [ADDR_W-1:0] r_pc;
    logic              r_miss;
    logic              r_fault;

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_jmp;
    logic [ADDR_W-1:0] w_ret;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_ras_top;
    logic [CNT_W-1:0]  w_ras_count;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_push;
    logic              w_pop;
    logic              w_misalign;
    next_src_t         w_src;
    next_src_t         w_sel;
    logic              w_unused;

    assign w_seq = r_pc + ADDR_W'(4);
    assign w_br  = w_seq + {{(ADDR_W-OFFSET_MSB-3){bus.instruction[OFFSET_MSB]}},
                            bus.instruction[OFFSET_MSB:0], 2'b00};
    assign w_jmp = {w_seq[ADDR_W-1:28], bus.instruction[JIDX_MSB:0], 2'b00};
    assign w_ret = w_ras_empty ? bus.rs_data : w_ras_top;

    assign w_push = bus.jump_sel & bus.link_sel & ~bus.jr_sel;
    assign w_pop  = bus.jr_sel & bus.ret_sel;

    always_comb begin
        w_src = SEQ;
        if (bus.jr_sel)
            w_src = bus.ret_sel ? RET : JR;
        else if (bus.jump_sel)
            w_src = JMP;
        else if (bus.branch_sel && bus.zero)
            w_src = BR;
    end

    // Only register-sourced targets can carry low address bits.
    always_comb begin
        w_misalign = 1'b0;
        if (w_src == JR)
            w_misalign = |bus.rs_data[1:0];
        else if (w_src == RET)
            w_misalign = |w_ret[1:0];
    end

    assign w_sel = w_misalign ? TRAP : w_src;

    always_comb begin
        w_next_pc = w_seq;
        case (w_sel)
            BR:      w_next_pc = w_br;
            JMP:     w_next_pc = w_jmp;
            JR:      w_next_pc = bus.rs_data;
            RET:     w_next_pc = w_ret;
            TRAP:    w_next_pc = c_trap_pc;
            default: w_next_pc = w_seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= c_reset_pc;
            r_miss  <= 1'b0;
            r_fault <= 1'b0;
        end else if (bus.stall) begin
            r_miss  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_pc    <= w_next_pc;
            r_miss  <= w_pop & w_ras_empty;
            r_fault <= w_misalign;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .hold  (bus.stall),
        .din   (w_seq),
        .top   (w_ras_top),
        .count (w_ras_count),
        .empty (w_ras_empty),
        .full  (w_ras_full)
    );

    assign bus.pc             = r_pc;
    assign bus.pc_plus4       = w_seq;
    assign bus.link_addr      = w_seq;
    assign bus.ras_count      = w_ras_count;
    assign bus.ras_miss       = r_miss;
    assign bus.misalign_fault = r_fault;

    assign w_unused = ^{bus.instruction[31:JIDX_MSB+1], w_ras_full};

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int RAS_DEPTH = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pc_sequencer_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

    pc_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (32'h0000_1000),
        .TRAP_VEC  (32'h0000_0080),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.stall       = 1'b0;
        bus.instruction = 32'h0;
        bus.zero        = 1'b0;
        bus.branch_sel  = 1'b0;
        bus.jump_sel    = 1'b0;
        bus.link_sel    = 1'b0;
        bus.jr_sel      = 1'b0;
        bus.ret_sel     = 1'b0;
        bus.rs_data     = '0;
    endtask

    task automatic jr_to(input logic [31:0] addr);
        idle();
        bus.jr_sel  = 1'b1;
        bus.rs_data = addr;
        step();
        idle();
    endtask

    task automatic jal(input logic [25:0] idx);
        idle();
        bus.jump_sel    = 1'b1;
        bus.link_sel    = 1'b1;
        bus.instruction = {6'b000011, idx};
        step();
        idle();
    endtask

    task automatic ret(input logic [31:0] rs);
        idle();
        bus.jr_sel  = 1'b1;
        bus.ret_sel = 1'b1;
        bus.rs_data = rs;
        step();
        idle();
    endtask

    localparam logic [31:0] c_call_pc [5]  = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
    localparam logic [31:0] c_ret_exp [4]  = '{32'h504, 32'h404, 32'h304, 32'h204};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst = 1'b1;
        step();
        step();
        check("reset_pc", bus.pc, 64'h1000);
        check("reset_cnt", bus.ras_count, 64'h0);
        check("reset_miss", bus.ras_miss, 64'h0);
        check("reset_fault", bus.misalign_fault, 64'h0);

        rst = 1'b0;
        step(); check("seq_1", bus.pc, 64'h1004);
        step(); check("seq_2", bus.pc, 64'h1008);
        step(); check("seq_3", bus.pc, 64'h100C);
        check("pc_plus4", bus.pc_plus4, 64'h1010);

        // Branch taken and not taken from 0x1010 with offset -4 words.
        jr_to(32'h1010);
        bus.instruction = 32'h1000_FFFC; bus.branch_sel = 1'b1; bus.zero = 1'b1;
        step(); idle();
        check("br_taken", bus.pc, 64'h1004);
        jr_to(32'h1010);
        bus.instruction = 32'h1000_FFFC; bus.branch_sel = 1'b1; bus.zero = 1'b0;
        step(); idle();
        check("br_not_taken", bus.pc, 64'h1014);

        // Call and predicted return.
        jr_to(32'h1020);
        check("link_addr", bus.link_addr, 64'h1024);
        jal(26'h0000400);
        check("jal_pc", bus.pc, 64'h1000);
        check("jal_cnt", bus.ras_count, 64'h1);
        ret(32'hDEAD_0000);
        check("ret_pc", bus.pc, 64'h1024);
        check("ret_cnt", bus.ras_count, 64'h0);
        check("ret_hit_nomiss", bus.ras_miss, 64'h0);

        // Overflow: five calls into a four-entry stack.
        for (int i = 0; i < 5; i++) begin
            jr_to(c_call_pc[i]);
            jal(26'h0000400);
        end
        check("ovf_cnt", bus.ras_count, 64'h4);
        for (int i = 0; i < 4; i++) begin
            ret(32'hDEAD_0000);
            check($sformatf("ovf_ret_%0d", i), bus.pc, {32'h0, c_ret_exp[i]});
        end
        check("drain_cnt", bus.ras_count, 64'h0);
        ret(32'h0000_3000);
        check("udf_pc", bus.pc, 64'h3000);
        check("udf_miss", bus.ras_miss, 64'h1);
        step();
        check("udf_miss_clear", bus.ras_miss, 64'h0);
        check("udf_next_pc", bus.pc, 64'h3004);

        // Stall ignores a pending jump for two cycles.
        bus.stall = 1'b1; bus.jump_sel = 1'b1; bus.instruction = 32'h0800_0123;
        step(); check("stall_1", bus.pc, 64'h3004);
        step(); check("stall_2", bus.pc, 64'h3004);
        bus.stall = 1'b0; bus.branch_sel = 1'b1; bus.zero = 1'b1;
        step(); idle();
        check("jmp_over_br", bus.pc, 64'h48C);

        // Misaligned register target traps.
        jr_to(32'h1002);
        check("trap_pc", bus.pc, 64'h80);
        check("trap_fault", bus.misalign_fault, 64'h1);
        step();
        check("trap_fault_clear", bus.misalign_fault, 64'h0);
        check("trap_next_pc", bus.pc, 64'h84);

        // Stalled return holds RAS, then reset lands mid-stall.
        jal(26'h0000400);
        check("jal2_cnt", bus.ras_count, 64'h1);
        step();
        bus.stall = 1'b1; bus.jr_sel = 1'b1; bus.ret_sel = 1'b1; bus.rs_data = 32'h5000;
        step();
        check("stall_ret_pc", bus.pc, 64'h1004);
        check("stall_ret_cnt", bus.ras_count, 64'h1);
        rst = 1'b1;
        step();
        check("rst_stall_pc", bus.pc, 64'h1000);
        check("rst_stall_cnt", bus.ras_count, 64'h0);
        rst = 1'b0;
        idle();
        step();
        check("post_rst_pc", bus.pc, 64'h1004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
